array_bubble_pass: RTL and testbench

- Downstream repair stage for the array sort checker.
- When the checker finishes and reports the array unsorted, this block is started and bubble-sorts the same array in place.
- Works through the shared array memory port. On completion the checker can be re-run and will report sorted.
- Uses an in-place compare/swap FSM. The memory has asynchronous read and synchronous write.

---
 rtl/array_bubble_pass.sv | 204 ++++++++++++++++++++
 tb/tb_array_bubble_pass.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/array_bubble_pass.sv
// array_bubble_pass
//   In-place bubble sort over a shared array memory (asynchronous read,
//   synchronous write). Started by go when the upstream checker reports the
//   array unsorted; when done, re-running the checker reports sorted.
//
//   Optional build macro: BUBBLE_SIGNED_COMPARE_EN
//     defined   -> element compare is signed two's-complement
//     undefined -> element compare is unsigned
//
//   Ports
//     clock        in   rising-edge clock
//     reset        in   asynchronous active-low reset
//     go           in   start request, honoured only in IDLE or DONE
//     base_addr    in   address of element 0 (captured on accepted go)
//     length       in   element count (captured on accepted go)
//     mem_addr     out  array memory address (holds last value in IDLE/DONE)
//     mem_rdata    in   combinational read data for mem_addr
//     mem_wdata    out  write data
//     mem_we       out  write enable, high only in WRA/WRB
//     busy         out  high outside IDLE and DONE
//     done         out  high while in DONE
//     swap_count   out  saturating swap count for the current run
//     pass_count   out  saturating completed-pass count for the current run
module array_bubble_pass #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_count,
  output logic [CNT_W-1:0]  pass_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_WRA,
    S_WRB,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_TWO  = (ADDR_W+1)'(2);
  localparam logic [ADDR_W+1:0] EXT_TWO  = (ADDR_W+2)'(2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     limit_q, limit_d;
  logic [ADDR_W:0]     i_q, i_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                swapped_q, swapped_d;
  logic [CNT_W-1:0]    swap_cnt_q, swap_cnt_d;
  logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [ADDR_W-1:0]   addr_lo;
  logic [ADDR_W-1:0]   addr_hi;
  logic [ADDR_W+1:0]   i_plus2;
  logic                gt;
  logic                advance;
  logic                swapped_now;

  // Addresses wrap modulo the memory size, so an array may straddle the top.
  assign addr_lo = base_q + i_q[ADDR_W-1:0];
  assign addr_hi = addr_lo + ADDR_ONE;
  assign i_plus2 = {1'b0, i_q} + EXT_TWO;

  always_comb begin
`ifdef BUBBLE_SIGNED_COMPARE_EN
    gt = $signed(a_q) > $signed(mem_rdata);
`else
    gt = a_q > mem_rdata;
`endif
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign swap_count = swap_cnt_q;
  assign pass_count = pass_cnt_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    limit_d     = limit_q;
    i_d         = i_q;
    a_d         = a_q;
    b_d         = b_q;
    swapped_d   = swapped_q;
    swap_cnt_d  = swap_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    mem_we      = 1'b0;
    advance     = 1'b0;
    swapped_now = swapped_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          base_d     = base_addr;
          limit_d    = length;
          i_d        = '0;
          swapped_d  = 1'b0;
          swap_cnt_d = '0;
          pass_cnt_d = '0;
          state_d    = (length < LEN_TWO) ? S_DONE : S_RDA;
        end
      end
      S_RDA: begin
        mem_addr = addr_lo;
        a_d      = mem_rdata;
        state_d  = S_RDB;
      end
      S_RDB: begin
        mem_addr = addr_hi;
        b_d      = mem_rdata;
        if (gt) begin
          state_d = S_WRA;
        end else begin
          advance = 1'b1;
        end
      end
      S_WRA: begin
        mem_addr  = addr_lo;
        mem_wdata = b_q;
        mem_we    = 1'b1;
        state_d   = S_WRB;
      end
      S_WRB: begin
        mem_addr    = addr_hi;
        mem_wdata   = a_q;
        mem_we      = 1'b1;
        swapped_d   = 1'b1;
        swapped_now = 1'b1;
        swap_cnt_d  = (&swap_cnt_q) ? swap_cnt_q : swap_cnt_q + CNT_ONE;
        advance     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared step to the next pair; swapped_now folds in a swap completing
    // in this same WRB cycle so the pass-end decision sees it.
    if (advance) begin
      if (i_plus2 < {1'b0, limit_q}) begin
        i_d     = i_q + LEN_ONE;
        state_d = S_RDA;
      end else begin
        pass_cnt_d = (&pass_cnt_q) ? pass_cnt_q : pass_cnt_q + CNT_ONE;
        if (swapped_now && (limit_q > LEN_TWO)) begin
          limit_d   = limit_q - LEN_ONE;
          i_d       = '0;
          swapped_d = 1'b0;
          state_d   = S_RDA;
        end else begin
          state_d = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      limit_q    <= '0;
      i_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      swapped_q  <= 1'b0;
      swap_cnt_q <= '0;
      pass_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      limit_q    <= limit_d;
      i_q        <= i_d;
      a_q        <= a_d;
      b_q        <= b_d;
      swapped_q  <= swapped_d;
      swap_cnt_q <= swap_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      addr_q     <= mem_addr;
      wdata_q    <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_array_bubble_pass.sv
// Scoreboard bench for array_bubble_pass: each run pushes its hand-computed
// final array, counters, go-to-done latency and write-cycle count; a monitor
// compares them when done rises.
module tb_array_bubble_pass;

  logic        clock;
  logic        reset;
  logic        go;
  logic [4:0]  base_addr;
  logic [5:0]  length;
  logic [4:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic [15:0] swap_count;
  logic [15:0] pass_count;

  array_bubble_pass #(
    .ADDR_W(5),
    .DATA_W(32),
    .CNT_W (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .go        (go),
    .base_addr (base_addr),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done),
    .swap_count(swap_count),
    .pass_count(pass_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [32];
  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  typedef struct {
    string       name;
    int unsigned base;
    int unsigned len;
    logic [31:0] data [4];
    int unsigned swaps;
    int unsigned passes;
    int unsigned lat;
    int unsigned wes;
  } exp_t;

  exp_t sb [$];

  int vectors = 0;
  int miscompares = 0;

  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned we_cnt = 0;
  logic        pending = 1'b0;

  // Edge bookkeeping: the edge that accepts go is counted as edge 1.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      pending <= 1'b0;
    end else if (go && !busy) begin
      pending   <= 1'b1;
      start_cyc <= cyc + 1;
      we_cnt    <= 0;
    end else begin
      if (mem_we) we_cnt <= we_cnt + 1;
      if (done) pending <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (pending && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done with empty scoreboard expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int unsigned k = 0; k < e.len && k < 4; k++)
          chk($sformatf("%s.mem[%0d]", e.name, k), 64'(mem[(e.base + k) % 32]), 64'(e.data[k]));
        chk({e.name, ".swap_count"}, 64'(swap_count), 64'(e.swaps));
        chk({e.name, ".pass_count"}, 64'(pass_count), 64'(e.passes));
        chk({e.name, ".latency"}, 64'(cyc - start_cyc + 1), 64'(e.lat));
        chk({e.name, ".we_cycles"}, 64'(we_cnt), 64'(e.wes));
      end
    end
  end

  task automatic wait_drain(input string nm);
    for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge clock);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s.timeout: got no done expected done within 400 cycles", nm);
      sb.delete();
    end
  endtask

  task automatic run(input string nm, input int unsigned b, input int unsigned len,
                     input logic [31:0] init [4], input logic [31:0] expd [4],
                     input int unsigned sw, input int unsigned ps,
                     input int unsigned lat, input int unsigned we,
                     input int unsigned hold);
    exp_t e;
    for (int unsigned k = 0; k < len && k < 4; k++) mem[(b + k) % 32] = init[k];
    base_addr = b[4:0];
    length    = len[5:0];
    go        = 1'b1;
    e.name = nm; e.base = b; e.len = len; e.data = expd;
    e.swaps = sw; e.passes = ps; e.lat = lat; e.wes = we;
    sb.push_back(e);
    @(negedge clock);
    if (hold > 1) begin
      // Changing the inputs while busy must not affect the run.
      base_addr = 5'd3;
      length    = 6'd2;
      repeat (hold - 1) @(negedge clock);
    end
    go = 1'b0;
    wait_drain(nm);
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    reset     = 1'b0;
    go        = 1'b0;
    base_addr = '0;
    length    = '0;
    repeat (2) @(negedge clock);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.mem_we", 64'(mem_we), 64'd0);
    chk("rst.mem_addr", 64'(mem_addr), 64'd0);
    chk("rst.mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst.swap_count", 64'(swap_count), 64'd0);
    chk("rst.pass_count", 64'(pass_count), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    run("sort3", 0, 3, '{3, 1, 2, 0}, '{1, 2, 3, 0}, 2, 2, 11, 4, 1);
    run("sorted4_gohold", 10, 4, '{1, 2, 3, 4}, '{1, 2, 3, 4}, 0, 1, 7, 0, 4);
    run("len0", 5, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 1, 0, 1);
    run("len1", 7, 1, '{42, 0, 0, 0}, '{42, 0, 0, 0}, 0, 0, 1, 0, 1);
    run("wrap", 30, 4, '{9, 7, 5, 3}, '{3, 5, 7, 9}, 6, 3, 25, 12, 1);
`ifdef BUBBLE_SIGNED_COMPARE_EN
    run("signcmp", 20, 2, '{32'hFFFF_FFFF, 1, 0, 0}, '{32'hFFFF_FFFF, 1, 0, 0}, 0, 1, 3, 0, 1);
`else
    run("signcmp", 20, 2, '{32'hFFFF_FFFF, 1, 0, 0}, '{1, 32'hFFFF_FFFF, 0, 0}, 1, 1, 5, 2, 1);
`endif

    // Abort a run in WRB: first compare 6>5 has written mem[8]=5 only.
    mem[8] = 6; mem[9] = 5; mem[10] = 1;
    base_addr = 5'd8;
    length    = 6'd3;
    go        = 1'b1;
    @(negedge clock);
    go = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort.busy_in_wrb", 64'(busy), 64'd1);
    chk("abort.we_in_wrb", 64'(mem_we), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.mem_we", 64'(mem_we), 64'd0);
    chk("abort.mem_addr", 64'(mem_addr), 64'd0);
    chk("abort.mem_wdata", 64'(mem_wdata), 64'd0);
    chk("abort.swap_count", 64'(swap_count), 64'd0);
    chk("abort.pass_count", 64'(pass_count), 64'd0);
    chk("abort.half_written", 64'(mem[8]), 64'd5);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run("rerun", 8, 3, '{5, 5, 1, 0}, '{1, 5, 5, 0}, 2, 2, 11, 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
